// File: rtl/alu_sequencer.sv
// Command-side controller for a 16-bit ripple ALU. It drives the ALU's operand
// and control inputs, waits one cycle for the ripple chain to settle, then
// captures the result and flags. SLL and SRL are done here, one bit per cycle.
module alu_sequencer #(
    parameter int unsigned W   = 16,
    parameter int unsigned SHW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_func,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    input  logic [SHW-1:0] cmd_shamt,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_ainvert,
    output logic           alu_bnegate,
    output logic           alu_cin,
    output logic [2:0]     alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_cout,
    input  logic           alu_overflow,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zero,
    output logic           rsp_cout,
    output logic           rsp_overflow
);

    localparam logic [2:0] F_AND = 3'd0;
    localparam logic [2:0] F_OR  = 3'd1;
    localparam logic [2:0] F_ADD = 3'd2;
    localparam logic [2:0] F_SUB = 3'd3;
    localparam logic [2:0] F_SLT = 3'd4;
    localparam logic [2:0] F_NOR = 3'd5;
    localparam logic [2:0] F_SLL = 3'd6;
    localparam logic [2:0] F_SRL = 3'd7;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [2:0]     r_func, w_func_nxt;
    logic [W-1:0]   r_shreg, w_shreg_nxt;
    logic [SHW-1:0] r_cnt, w_cnt_nxt;
    logic           r_cmd_ready, w_cmd_ready_nxt;
    logic [W-1:0]   r_alu_a, w_alu_a_nxt;
    logic [W-1:0]   r_alu_b, w_alu_b_nxt;
    logic           r_ainv, w_ainv_nxt;
    logic           r_bneg, w_bneg_nxt;
    logic           r_cin, w_cin_nxt;
    logic [2:0]     r_op, w_op_nxt;
    logic           r_rsp_valid, w_rsp_valid_nxt;
    logic [W-1:0]   r_rsp_result, w_rsp_result_nxt;
    logic           r_rsp_zero, w_rsp_zero_nxt;
    logic           r_rsp_cout, w_rsp_cout_nxt;
    logic           r_rsp_ovf, w_rsp_ovf_nxt;
    logic           w_accept;

    assign w_accept = cmd_valid & r_cmd_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (cmd_func >= F_SLL) ? S_SHIFT : S_EXEC;
            S_EXEC:  w_state_nxt = S_DONE;
            S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values: decode on accept, capture in EXEC, shift in SHIFT
    always_comb begin
        w_func_nxt       = r_func;
        w_shreg_nxt      = r_shreg;
        w_cnt_nxt        = r_cnt;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_ainv_nxt       = r_ainv;
        w_bneg_nxt       = r_bneg;
        w_cin_nxt        = r_cin;
        w_op_nxt         = r_op;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_zero_nxt   = r_rsp_zero;
        w_rsp_cout_nxt   = r_rsp_cout;
        w_rsp_ovf_nxt    = r_rsp_ovf;
        w_cmd_ready_nxt  = (w_state_nxt == S_IDLE);
        w_rsp_valid_nxt  = (w_state_nxt == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_func_nxt  = cmd_func;
                    w_alu_a_nxt = cmd_a;
                    w_alu_b_nxt = cmd_b;
                    w_shreg_nxt = cmd_a;
                    w_cnt_nxt   = cmd_shamt;
                    w_ainv_nxt  = 1'b0;
                    w_bneg_nxt  = 1'b0;
                    w_cin_nxt   = 1'b0;
                    w_op_nxt    = OP_AND;
                    case (cmd_func)
                        F_OR:  w_op_nxt = OP_OR;
                        F_ADD: w_op_nxt = OP_ADD;
                        F_SUB, F_SLT: begin
                            w_bneg_nxt = 1'b1;
                            w_cin_nxt  = 1'b1;
                            w_op_nxt   = OP_ADD;
                        end
                        F_NOR: begin
                            w_ainv_nxt = 1'b1;
                            w_bneg_nxt = 1'b1;
                        end
                        default: w_op_nxt = OP_AND;
                    endcase
                end
            end
            S_EXEC: begin
                w_rsp_result_nxt = alu_result;
                w_rsp_cout_nxt   = 1'b0;
                w_rsp_ovf_nxt    = 1'b0;
                if (r_func == F_SLT) begin
                    // Sign of the true difference: MSB corrected by overflow
                    w_rsp_result_nxt = W'(alu_result[W-1] ^ alu_overflow);
                end else if ((r_func == F_ADD) || (r_func == F_SUB)) begin
                    w_rsp_cout_nxt = alu_cout;
                    w_rsp_ovf_nxt  = alu_overflow;
                end
                w_rsp_zero_nxt = (w_rsp_result_nxt == '0);
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_rsp_result_nxt = r_shreg;
                    w_rsp_zero_nxt   = (r_shreg == '0);
                    w_rsp_cout_nxt   = 1'b0;
                    w_rsp_ovf_nxt    = 1'b0;
                end else begin
                    w_shreg_nxt = (r_func == F_SRL) ? {1'b0, r_shreg[W-1:1]}
                                                    : {r_shreg[W-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - SHW'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func       <= '0;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_ainv       <= 1'b0;
            r_bneg       <= 1'b0;
            r_cin        <= 1'b0;
            r_op         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_cout   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
        end else begin
            r_func       <= w_func_nxt;
            r_shreg      <= w_shreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_ainv       <= w_ainv_nxt;
            r_bneg       <= w_bneg_nxt;
            r_cin        <= w_cin_nxt;
            r_op         <= w_op_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_zero   <= w_rsp_zero_nxt;
            r_rsp_cout   <= w_rsp_cout_nxt;
            r_rsp_ovf    <= w_rsp_ovf_nxt;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_ainvert  = r_ainv;
    assign alu_bnegate  = r_bneg;
    assign alu_cin      = r_cin;
    assign alu_op       = r_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_overflow = r_rsp_ovf;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ripple ALU closes the loop, and every
// response is compared with results computed from plain integer arithmetic.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_func = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  cmd_shamt = '0;
    logic [15:0] alu_a, alu_b;
    logic        alu_ainvert, alu_bnegate, alu_cin;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_cout, alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.W(16), .SHW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ainvert(alu_ainvert),
        .alu_bnegate(alu_bnegate), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow)
    );

    // Behavioural 16-bit ALU driven by the sequencer
    logic [15:0] m_aa, m_bb;
    logic [16:0] m_sum;
    always_comb begin
        m_aa  = alu_ainvert ? ~alu_a : alu_a;
        m_bb  = alu_bnegate ? ~alu_b : alu_b;
        m_sum = {1'b0, m_aa} + {1'b0, m_bb} + 17'(alu_cin);
        case (alu_op)
            3'b000:  alu_result = m_aa & m_bb;
            3'b001:  alu_result = m_aa | m_bb;
            3'b010:  alu_result = m_sum[15:0];
            default: alu_result = 16'h0000;
        endcase
        alu_cout     = m_sum[16];
        alu_overflow = (m_aa[15] == m_bb[15]) && (m_sum[15] != m_aa[15]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: expected response from the function definitions
    task automatic ref_model(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] sh, output logic [15:0] r, output logic c,
                             output logic v, output int lat);
        int sa, sb, t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        lat = 2;
        case (f)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                t = a + b;
                r = 16'(t);
                c = (t > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'd3: begin
                r = a - b;
                c = (a >= b);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3'd4: r = (sa < sb) ? 16'd1 : 16'd0;
            3'd5: r = ~(a | b);
            3'd6: begin r = a << sh; lat = int'(sh) + 2; end
            default: begin r = a >> sh; lat = int'(sh) + 2; end
        endcase
    endtask

    // Issue one command, check latency/result, hold the response, then retire it
    task automatic run_op(input string tag, input logic [2:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] sh, input int hold);
        logic [15:0] er;
        logic        ec, ev;
        int          elat, lat;
        logic [5:0]  ectl;
        ref_model(f, a, b, sh, er, ec, ev, elat);
        case (f)
            3'd1:       ectl = 6'b000_001;
            3'd2:       ectl = 6'b000_010;
            3'd3, 3'd4: ectl = 6'b011_010;
            3'd5:       ectl = 6'b110_000;
            default:    ectl = 6'b000_000;
        endcase
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; cmd_shamt = sh;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        lat = 1;
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, "_alu_b"}, 32'(alu_b), 32'(b));
        if (f < 3'd6)
            chk({tag, "_alu_ctl"}, 32'({alu_ainvert, alu_bnegate, alu_cin, alu_op}), 32'(ectl));
        chk({tag, "_busy"}, 32'(cmd_ready), 32'd0);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                cmd_valid = 1'b1;
                cmd_func = 3'($urandom);
                @(negedge clk);
            end
            chk({tag, "_result"}, 32'(rsp_result), 32'(er));
            chk({tag, "_flags"}, 32'({rsp_valid, rsp_zero, rsp_cout, rsp_overflow, cmd_ready}),
                32'({1'b1, er == 16'h0, ec, ev, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({tag, "_retired"}, 32'({rsp_valid, cmd_ready}), 32'b01);
        chk({tag, "_stale"}, 32'(rsp_result), 32'(er));
    endtask

    initial begin
        logic [2:0] rf;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_ctl", 32'({alu_ainvert, alu_bnegate, alu_cin, alu_op}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_zero, rsp_cout, rsp_overflow, cmd_ready, rsp_result}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 32'(cmd_ready), 32'd1);

        // Directed cases
        run_op("add_ovf", 3'd2, 16'h7FFF, 16'h0001, 4'd0, 0);
        run_op("sub_zero", 3'd3, 16'h0005, 16'h0005, 4'd0, 1);
        run_op("slt_neg", 3'd4, 16'h8000, 16'h0001, 4'd0, 0);
        run_op("slt_swap", 3'd4, 16'h0001, 16'h8000, 4'd0, 0);
        run_op("nor", 3'd5, 16'h00F0, 16'h0F00, 4'd0, 0);
        run_op("sll15", 3'd6, 16'h0001, 16'h1234, 4'd15, 0);
        run_op("srl0_hold", 3'd7, 16'h8000, 16'h0000, 4'd0, 5);
        run_op("and", 3'd0, 16'hF0F0, 16'h3C3C, 4'd0, 0);
        run_op("or", 3'd1, 16'hF000, 16'h000F, 4'd0, 0);
        run_op("add_wrap", 3'd2, 16'hFFFF, 16'h0001, 4'd0, 0);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d", i), rf, 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        // Reset pulse in the middle of a shift discards the command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_func = 3'd6; cmd_a = 16'h00FF; cmd_shamt = 4'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        chk("midrst_alu_b", 32'(alu_b), 32'd0);
        chk("midrst_ctl", 32'({alu_ainvert, alu_bnegate, alu_cin, alu_op}), 32'd0);
        chk("midrst_rsp", 32'({rsp_valid, rsp_zero, rsp_cout, rsp_overflow, cmd_ready, rsp_result}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        run_op("post_rst", 3'd3, 16'h0003, 16'h0007, 4'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
